// File: rtl/vector_checker.sv
// vector_checker: masked response checker with saturating counters and LFSR signature of actual outputs.
// Optional first-mismatch capture is built when VECTOR_CHECKER_FIRSTERR_EN is defined.
module vector_checker #(
  parameter int DATA_W = 2,
  parameter int HASH_W = 7,
  parameter int TAP    = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              valid,
  input  logic              last,
  input  logic [DATA_W-1:0] actual,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vector_count,
  output logic [CNT_W-1:0]  error_count,
  output logic [HASH_W-1:0] hash,
  output logic              first_err_valid,
  output logic [CNT_W-1:0]  first_err_idx
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic accept, mismatch;
  logic [HASH_W-1:0] h1;
  assign accept   = (state == RUN) && valid && !start;
  assign mismatch = |((actual ^ expected) & mask);
  assign h1       = hash ^ HASH_W'(actual);
  assign busy     = state == RUN;
  assign done     = state == DONE;
  assign pass     = done && (error_count == '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      vector_count <= '0;
      error_count  <= '0;
      hash         <= '0;
    end else if (start) begin
      state        <= RUN;
      vector_count <= '0;
      error_count  <= '0;
      hash         <= '0;
    end else if (accept) begin
      vector_count <= &vector_count ? vector_count : vector_count + CNT_W'(1);
      error_count  <= (mismatch && !(&error_count)) ? error_count + CNT_W'(1) : error_count;
      hash         <= {h1[HASH_W-2:0], h1[HASH_W-1] ^ h1[TAP]};
      state        <= last ? DONE : RUN;
    end
  end
`ifdef VECTOR_CHECKER_FIRSTERR_EN
  always_ff @(posedge clk) begin
    if (reset || start) begin
      first_err_valid <= 1'b0;
      first_err_idx   <= '0;
    end else if (accept && mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_idx   <= vector_count;
    end
  end
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx   = '0;
`endif
endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: directed stimulus, spec-level model checked every cycle, plus literal expectations.
module tb_vector_checker;
`ifdef VECTOR_CHECKER_FIRSTERR_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [1:0] actual = '0, expected = '0, mask = '0;
  logic busy, done, pass, fev;
  logic [31:0] vc, ec, fei;
  logic [6:0] hash;
  logic busy2, done2, pass2, fev2;
  logic [1:0] vc2, ec2, fei2;
  logic [6:0] hash2;
  int checks = 0, errors = 0;

  vector_checker dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
    .actual(actual), .expected(expected), .mask(mask),
    .busy(busy), .done(done), .pass(pass), .vector_count(vc), .error_count(ec),
    .hash(hash), .first_err_valid(fev), .first_err_idx(fei)
  );
  vector_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .last(last),
    .actual(actual), .expected(expected), .mask(mask),
    .busy(busy2), .done(done2), .pass(pass2), .vector_count(vc2), .error_count(ec2),
    .hash(hash2), .first_err_valid(fev2), .first_err_idx(fei2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw beat count n and mismatch count ne; saturation applied only when predicting outputs.
  bit m_busy, m_done, m_fev;
  int n, ne, m_fei;
  int m_hash;
  function automatic int sat(input int x, input int mx);
    return x > mx ? mx : x;
  endfunction
  always @(posedge clk) begin
    int h1;
    if (reset) begin
      m_busy = 0; m_done = 0; n = 0; ne = 0; m_hash = 0; m_fev = 0; m_fei = 0;
    end else if (start) begin
      m_busy = 1; m_done = 0; n = 0; ne = 0; m_hash = 0; m_fev = 0; m_fei = 0;
    end else if (m_busy && valid) begin
      if (((actual ^ expected) & mask) != 0) begin
        if (!m_fev) begin m_fev = 1; m_fei = n; end
        ne++;
      end
      n++;
      h1 = m_hash ^ int'(actual);
      m_hash = ((h1 * 2) % 128) + (((h1 / 64) ^ (h1 / 32)) % 2);
      if (last) begin m_busy = 0; m_done = 1; end
    end
    #1;
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("pass", pass, m_done && ne == 0);
    chk("vector_count", vc, n);
    chk("error_count", ec, ne);
    chk("hash", hash, m_hash);
    chk("first_err_valid", fev, FE && m_fev);
    chk("first_err_idx", fei, FE ? m_fei : 0);
    chk("busy2", busy2, m_busy);
    chk("done2", done2, m_done);
    chk("pass2", pass2, m_done && ne == 0);
    chk("vector_count2", vc2, sat(n, 3));
    chk("error_count2", ec2, sat(ne, 3));
    chk("hash2", hash2, m_hash);
    chk("first_err_idx2", fei2, FE ? sat(m_fei, 3) : 0);
  end

  task automatic step(input bit s, input bit v, input bit l, input logic [1:0] a, input logic [1:0] e, input logic [1:0] m);
    start = s; valid = v; last = l; actual = a; expected = e; mask = m;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("lit_reset_busy", busy, 0);
    chk("lit_reset_hash", hash, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("lit_start_busy", busy, 1);
    step(0, 1, 0, 2'b01, 2'b01, 2'b11);
    step(0, 1, 0, 2'b10, 2'b10, 2'b11);
    step(0, 1, 1, 2'b11, 2'b11, 2'b11);
    chk("lit_run1_vc", vc, 3);
    chk("lit_run1_ec", ec, 0);
    chk("lit_run1_hash", hash, 7'h06);
    chk("lit_run1_done", done, 1);
    chk("lit_run1_pass", pass, 1);
    step(0, 1, 1, 2'b11, 2'b00, 2'b11);
    chk("lit_done_valid_vc", vc, 3);
    chk("lit_done_valid_hash", hash, 7'h06);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2'b01, 2'b01, 2'b11);
    step(0, 1, 0, 2'b10, 2'b00, 2'b11);
    step(0, 1, 1, 2'b11, 2'b11, 2'b11);
    chk("lit_run2_ec", ec, 1);
    chk("lit_run2_pass", pass, 0);
    chk("lit_run2_hash", hash, 7'h06);
    chk("lit_run2_fev", fev, FE);
    chk("lit_run2_fei", fei, FE ? 1 : 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2'b01, 2'b01, 2'b01);
    step(0, 1, 0, 2'b10, 2'b00, 2'b01);
    step(0, 1, 1, 2'b11, 2'b11, 2'b01);
    chk("lit_mask_ec", ec, 0);
    chk("lit_mask_pass", pass, 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2'b01, 2'b01, 2'b11);
    step(1, 1, 0, 2'b11, 2'b00, 2'b11);
    chk("lit_restart_vc", vc, 0);
    chk("lit_restart_hash", hash, 0);
    chk("lit_restart_busy", busy, 1);
    step(0, 1, 1, 2'b10, 2'b10, 2'b11);
    chk("lit_restart_run_vc", vc, 1);
    chk("lit_restart_run_hash", hash, 7'h04);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 2'b01, 2'b01, 2'b11);
    step(0, 1, 0, 2'b10, 2'b01, 2'b11);
    reset = 1'b1;
    step(0, 1, 0, 2'b11, 2'b11, 2'b11);
    reset = 1'b0;
    chk("lit_midreset_busy", busy, 0);
    chk("lit_midreset_done", done, 0);
    chk("lit_midreset_vc", vc, 0);
    chk("lit_midreset_ec", ec, 0);
    chk("lit_midreset_hash", hash, 0);
    chk("lit_midreset_fev", fev, 0);
    step(0, 1, 1, 2'b11, 2'b00, 2'b11);
    chk("lit_idle_valid_vc", vc, 0);
    chk("lit_idle_valid_busy", busy, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, i == 4, 2'b01, 2'b10, 2'b11);
    chk("lit_sat_vc2", vc2, 3);
    chk("lit_sat_ec2", ec2, 3);
    chk("lit_sat_vc", vc, 5);
    chk("lit_sat_ec", ec, 5);
    chk("lit_sat_fei2", fei2, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable, parametrised response checker for on-chip self-test of small FSM designs such as the adventure-game labs. Each valid beat compares a DUT output vector against an expected vector under a care mask. The block counts vectors and mismatches and folds the actual outputs into an LFSR signature, so pass/fail and a hash are available without a simulator. It sits between a vector source (ROM or host) and the DUT outputs, one beat per clock.

## Interface
Parameters:
- DATA_W, 2, width of compared output vector (DATA_W ≤ HASH_W)
- HASH_W, 7, signature register width (≥ 2)
- TAP, 5, feedback tap index, 0 ≤ TAP < HASH_W-1
- CNT_W, 32, width of vector and error counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  begin (or restart) a check run
- valid  in  1  current beat carries a vector
- last  in  1  qualifies final beat of run (ignored unless valid)
- actual  in  DATA_W  DUT output vector
- expected  in  DATA_W  expected output vector
- mask  in  DATA_W  1 = compare bit, 0 = don't care
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  done and error_count == 0
- vector_count  out  CNT_W  beats accepted this run
- error_count  out  CNT_W  mismatching beats this run
- hash  out  HASH_W  signature of actual vectors
- first_err_valid  out  1  a mismatch has been captured (macro only)
- first_err_idx  out  CNT_W  vector index of first mismatch (macro only)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start → RUN; valid ignored.
- RUN: start → RUN with all counters, hash and capture cleared; a simultaneous valid beat is discarded. Otherwise valid beat accepted; valid & last → DONE after accepting the beat.
- DONE: outputs hold; start → RUN (cleared as above); valid ignored.
- Accepted beat:
  - vector_count += 1.
  - Mismatch iff ((actual ^ expected) & mask) != 0; error_count += 1 on mismatch.
  - Both counters saturate at all-ones.
  - Hash update: h1 = hash ^ zero-extend(actual); hash ← {h1[HASH_W-2:0], h1[HASH_W-1] ^ h1[TAP]}.
  - The hash covers all actual bits regardless of mask.
- pass is combinational from state and error_count: pass = done & (error_count == 0).
- Entering RUN from IDLE also clears counters and hash, so start behaves identically in every state.

## Timing
- Reset (sync): state IDLE; busy=done=pass=0; vector_count=error_count=0; hash=0; first_err_valid=0, first_err_idx=0.
- Reset has priority over start/valid. Reset mid-run abandons the run, with no done pulse.
- start sampled at edge N: busy=1 and counters/hash zero after edge N.
- Beat at edge N: counters and hash reflect it after edge N (1-cycle latency).
- last beat at edge N: done=1 and busy=0 after edge N. Final counts and hash include that beat.
- done is a level, held until start or reset.
- No backpressure: one beat per cycle at full rate, with no gaps required.

## Configuration
- VECTOR_CHECKER_FIRSTERR_EN defined:
  - On the first mismatching beat of a run, first_err_idx ← vector_count (0-based value before increment), and first_err_valid ← 1.
  - Both fields hold until start or reset.
  - Both clear on start.
- Not defined: first_err_valid and first_err_idx are tied to 0, and no capture registers are built.

## Test plan
- Defaults. Reset 2 cycles, start, then beats actual=01,10,11 with expected=actual, mask=11, last on third → vector_count=3, error_count=0, hash=7'h06, done=1, pass=1.
- Same stream with expected=00 on beat 2 → error_count=1, pass=0, hash=7'h06. With macro: first_err_valid=1, first_err_idx=1.
- Beat 2 mismatching only in bit 1 with mask=01 → error_count=0, pass=1.
- start asserted with valid in the middle of a run → that beat is discarded. The next cycle shows vector_count=0 and hash=0, and the following run counts from 0.
- Reset asserted mid-run after 2 beats → next cycle shows busy=0, done=0, counts=0, hash=0. valid in IDLE and in DONE changes nothing.
- CNT_W=2. Send 5 mismatching beats → vector_count=3 and error_count=3 (saturated).
